// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: vector issue sequencer driving start/FU/VL/mask broadcasts to the register files
module vec_issue_ctrl #(
    parameter int NREG      = 8,
    parameter int LOGDEPTH  = 6,
    parameter int RES_EXTRA = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic [2:0]          i_vi,
    input  logic [2:0]          i_vj,
    input  logic [2:0]          i_vk,
    input  logic                i_use_vj,
    input  logic                i_use_vk,
    input  logic [2:0]          i_fu,
    input  logic [LOGDEPTH:0]   i_vl,
    input  logic [63:0]         i_vm,
    input  logic [NREG-1:0]     i_busy,
    input  logic [NREG-1:0]     i_chain_n,
    output logic                o_ack,
    output logic                o_illegal,
    output logic [NREG-1:0]     o_vread_start,
    output logic [NREG-1:0]     o_vwrite_start,
    output logic [2:0]          o_fu,
    output logic [3:0]          o_fu_time,
    output logic [LOGDEPTH:0]   o_vector_length,
    output logic [63:0]         o_vector_mask,
    output logic [7:0]          o_fu_busy
);
    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, REJECT} state_t;
    localparam logic [LOGDEPTH:0] VL_MAX = (LOGDEPTH+1)'(1 << LOGDEPTH);
    localparam logic [3:0] FU_TIME [8] = '{4'd2, 4'd4, 4'd3, 4'd7, 4'd6, 4'd14, 4'd6, 4'd7};
    state_t            state;
    logic [2:0]        vi, vj, vk, fu;
    logic              use_vj, use_vk;
    logic [LOGDEPTH:0] vl;
    logic [63:0]       vm;
    logic [7:0]        cnt [8];
    logic              bad, j_ok, k_ok, go;
    logic [NREG-1:0]   rd_mask;
    always_comb begin
        bad = i_vl == '0 || i_vl > VL_MAX || (i_use_vj && i_vj == i_vi) || (i_use_vk && i_vk == i_vi);
        // a busy source is still readable during its chain slot
        j_ok = !use_vj || !i_busy[vj] || !i_chain_n[vj];
        k_ok = !use_vk || !i_busy[vk] || !i_chain_n[vk];
        go = cnt[fu] == '0 && !i_busy[vi] && j_ok && k_ok;
        rd_mask = (NREG'(use_vj) << vj) | (NREG'(use_vk) << vk);
        for (int f = 0; f < 8; f++) o_fu_busy[f] = cnt[f] != '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            o_ack <= 1'b0;
            o_illegal <= 1'b0;
            o_vread_start <= '0;
            o_vwrite_start <= '0;
            o_fu <= '0;
            o_fu_time <= '0;
            o_vector_length <= '0;
            o_vector_mask <= '0;
            for (int f = 0; f < 8; f++) cnt[f] <= '0;
        end else begin
            o_ack <= 1'b0;
            o_illegal <= 1'b0;
            o_vread_start <= '0;
            o_vwrite_start <= '0;
            for (int f = 0; f < 8; f++) if (cnt[f] != '0) cnt[f] <= cnt[f] - 8'd1;
            case (state)
                IDLE: if (i_valid && !o_ack) begin
                    // o_ack still high here means the host has not yet dropped the rejected request
                    vi <= i_vi;
                    vj <= i_vj;
                    vk <= i_vk;
                    use_vj <= i_use_vj;
                    use_vk <= i_use_vk;
                    fu <= i_fu;
                    vl <= i_vl;
                    vm <= i_vm;
                    state <= bad ? REJECT : CHECK;
                end
                CHECK: if (go) begin
                    state <= ISSUE;
                    o_vread_start <= rd_mask;
                    o_vwrite_start <= NREG'(1) << vi;
                    o_fu <= fu;
                    o_fu_time <= FU_TIME[fu];
                    o_vector_length <= vl;
                    o_vector_mask <= vm;
                    o_ack <= 1'b1;
                    cnt[fu] <= 8'(vl) + 8'(RES_EXTRA);
                end
                ISSUE: state <= IDLE;
                REJECT: begin
                    o_ack <= 1'b1;
                    o_illegal <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb_vec_issue_ctrl: directed vector table plus hand sequences for stalls, chaining, reservation and reset
module tb_vec_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [2:0]  i_vi, i_vj, i_vk, i_fu;
    logic        i_use_vj, i_use_vk;
    logic [6:0]  i_vl;
    logic [63:0] i_vm;
    logic [7:0]  i_busy, i_chain_n;
    logic        o_ack, o_illegal;
    logic [7:0]  o_vread_start, o_vwrite_start, o_fu_busy;
    logic [2:0]  o_fu;
    logic [3:0]  o_fu_time;
    logic [6:0]  o_vector_length;
    logic [63:0] o_vector_mask;
    int tests = 0;
    int fails = 0;

    vec_issue_ctrl dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_vi(i_vi), .i_vj(i_vj), .i_vk(i_vk),
        .i_use_vj(i_use_vj), .i_use_vk(i_use_vk), .i_fu(i_fu), .i_vl(i_vl), .i_vm(i_vm),
        .i_busy(i_busy), .i_chain_n(i_chain_n), .o_ack(o_ack), .o_illegal(o_illegal),
        .o_vread_start(o_vread_start), .o_vwrite_start(o_vwrite_start), .o_fu(o_fu),
        .o_fu_time(o_fu_time), .o_vector_length(o_vector_length), .o_vector_mask(o_vector_mask),
        .o_fu_busy(o_fu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vi, vj, vk;
        logic       uj, uk;
        logic [2:0] fu;
        logic [6:0] vl;
        logic       ill;
        logic [7:0] rd, wr;
        logic [3:0] ft;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] vi, input logic [2:0] vj, input logic [2:0] vk,
                        input logic uj, input logic uk, input logic [2:0] fu,
                        input logic [6:0] vl, input logic [63:0] vm, output int n);
        i_vi = vi; i_vj = vj; i_vk = vk; i_use_vj = uj; i_use_vk = uk;
        i_fu = fu; i_vl = vl; i_vm = vm; i_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ack && n < 200);
        chk("ack_seen", 64'(o_ack), 64'd1);
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (o_fu_busy != 8'h00 && k < 150) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(o_fu_busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"}, 64'(o_ack), 64'd0);
        chk({tag, "_ill"}, 64'(o_illegal), 64'd0);
        chk({tag, "_rd"}, 64'(o_vread_start), 64'd0);
        chk({tag, "_wr"}, 64'(o_vwrite_start), 64'd0);
        chk({tag, "_fu"}, 64'(o_fu), 64'd0);
        chk({tag, "_ft"}, 64'(o_fu_time), 64'd0);
        chk({tag, "_vl"}, 64'(o_vector_length), 64'd0);
        chk({tag, "_vm"}, o_vector_mask, 64'd0);
        chk({tag, "_fub"}, 64'(o_fu_busy), 64'd0);
    endtask

    initial begin
        int n, cnt;
        logic [63:0] vm;
        tbl[0]  = '{3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd2, 7'd10, 1'b0, 8'h0C, 8'h02, 4'd3};
        tbl[1]  = '{3'd0, 3'd5, 3'd0, 1'b1, 1'b0, 3'd0, 7'd1,  1'b0, 8'h20, 8'h01, 4'd2};
        tbl[2]  = '{3'd7, 3'd6, 3'd6, 1'b1, 1'b1, 3'd5, 7'd64, 1'b0, 8'h40, 8'h80, 4'd14};
        tbl[3]  = '{3'd3, 3'd4, 3'd5, 1'b1, 1'b1, 3'd1, 7'd33, 1'b0, 8'h30, 8'h08, 4'd4};
        tbl[4]  = '{3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 3'd4, 7'd5,  1'b0, 8'h00, 8'h04, 4'd6};
        tbl[5]  = '{3'd6, 3'd6, 3'd1, 1'b0, 1'b1, 3'd6, 7'd7,  1'b0, 8'h02, 8'h40, 4'd6};
        tbl[6]  = '{3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 3'd7, 7'd64, 1'b0, 8'h01, 8'h20, 4'd7};
        tbl[7]  = '{3'd4, 3'd0, 3'd1, 1'b1, 1'b1, 3'd3, 7'd2,  1'b0, 8'h03, 8'h10, 4'd7};
        tbl[8]  = '{3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd2, 7'd0,  1'b1, 8'h00, 8'h00, 4'd0};
        tbl[9]  = '{3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd2, 7'd65, 1'b1, 8'h00, 8'h00, 4'd0};
        tbl[10] = '{3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd2, 7'd127,1'b1, 8'h00, 8'h00, 4'd0};
        tbl[11] = '{3'd3, 3'd3, 3'd4, 1'b1, 1'b1, 3'd0, 7'd4,  1'b1, 8'h00, 8'h00, 4'd0};
        tbl[12] = '{3'd3, 3'd4, 3'd3, 1'b1, 1'b1, 3'd0, 7'd4,  1'b1, 8'h00, 8'h00, 4'd0};

        rst = 1'b1; i_valid = 1'b0; i_vi = '0; i_vj = '0; i_vk = '0; i_use_vj = 1'b0;
        i_use_vk = 1'b0; i_fu = '0; i_vl = '0; i_vm = '0; i_busy = '0; i_chain_n = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");

        for (int i = 0; i < 13; i++) begin
            vm = {56'h0123_4567_89AB_CD, 8'(i)};
            send(tbl[i].vi, tbl[i].vj, tbl[i].vk, tbl[i].uj, tbl[i].uk, tbl[i].fu, tbl[i].vl, vm, n);
            chk($sformatf("v%0d_lat", i), 64'(n), 64'd2);
            chk($sformatf("v%0d_ill", i), 64'(o_illegal), 64'(tbl[i].ill));
            chk($sformatf("v%0d_rd", i), 64'(o_vread_start), 64'(tbl[i].rd));
            chk($sformatf("v%0d_wr", i), 64'(o_vwrite_start), 64'(tbl[i].wr));
            if (!tbl[i].ill) begin
                chk($sformatf("v%0d_fu", i), 64'(o_fu), 64'(tbl[i].fu));
                chk($sformatf("v%0d_ft", i), 64'(o_fu_time), 64'(tbl[i].ft));
                chk($sformatf("v%0d_vl", i), 64'(o_vector_length), 64'(tbl[i].vl));
                chk($sformatf("v%0d_vm", i), o_vector_mask, vm);
                chk($sformatf("v%0d_fub", i), 64'(o_fu_busy), 64'(8'h01 << tbl[i].fu));
            end
            @(negedge clk);
            chk($sformatf("v%0d_ack_pulse", i), 64'(o_ack), 64'd0);
            chk($sformatf("v%0d_start_pulse", i), 64'(o_vread_start | o_vwrite_start), 64'd0);
            wait_idle();
        end

        send(3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 3'd2, 7'd10, 64'h1, n);
        cnt = 0;
        while (o_fu_busy[2] && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("vadd_res_len", 64'(cnt), 64'd14);
        wait_idle();

        i_busy = 8'h04;
        i_vi = 3'd1; i_vj = 3'd2; i_vk = 3'd3; i_use_vj = 1'b1; i_use_vk = 1'b1;
        i_fu = 3'd2; i_vl = 7'd8; i_vm = '1; i_valid = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(o_ack);
        end
        chk("chain_wait_noack", 64'(cnt), 64'd0);
        i_chain_n = 8'hFB;
        @(negedge clk);
        i_chain_n = 8'hFF;
        chk("chain_ack", 64'(o_ack), 64'd1);
        chk("chain_rd", 64'(o_vread_start), 64'h0C);
        i_valid = 1'b0; i_busy = 8'h00;
        wait_idle();

        i_busy = 8'h10;
        i_vi = 3'd4; i_vj = 3'd0; i_vk = 3'd1; i_fu = 3'd0; i_vl = 7'd3; i_valid = 1'b1;
        i_chain_n = 8'hEF;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            cnt += int'(o_ack);
        end
        chk("dst_busy_noack", 64'(cnt), 64'd0);
        i_busy = 8'h00; i_chain_n = 8'hFF;
        @(negedge clk);
        chk("dst_busy_ack", 64'(o_ack), 64'd1);
        chk("dst_busy_wr", 64'(o_vwrite_start), 64'h10);
        i_valid = 1'b0;
        wait_idle();

        send(3'd4, 3'd0, 3'd1, 1'b1, 1'b1, 3'd3, 7'd64, 64'h2, n);
        chk("fpmul1_lat", 64'(n), 64'd2);
        send(3'd5, 3'd2, 3'd3, 1'b1, 1'b1, 3'd3, 7'd64, 64'h3, n);
        chk("fpmul2_lat", 64'(n), 64'd69);
        chk("fpmul2_wr", 64'(o_vwrite_start), 64'h20);
        wait_idle();

        i_busy = 8'h02;
        i_vi = 3'd1; i_vj = 3'd2; i_vk = 3'd3; i_use_vj = 1'b1; i_use_vk = 1'b1;
        i_fu = 3'd4; i_vl = 7'd5; i_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pre_ack", 64'(o_ack), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0; i_valid = 1'b0; i_busy = 8'h00;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            cnt += int'(o_ack);
        end
        chk("rst_no_ack", 64'(cnt), 64'd0);
        send(3'd6, 3'd0, 3'd7, 1'b1, 1'b1, 3'd4, 7'd5, 64'h55, n);
        chk("post_rst_lat", 64'(n), 64'd2);
        chk("post_rst_rd", 64'(o_vread_start), 64'h81);
        chk("post_rst_wr", 64'(o_vwrite_start), 64'h40);
        chk("post_rst_ft", 64'(o_fu_time), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
